gpio_infilt: RTL

GPIO_INFILT -- requirements
Module: gpio_infilt

---
 rtl/gpio_pkg.sv | 7 +
 rtl/gpio_infilt_cell.sv | 83 ++++++++
 rtl/gpio_infilt.sv | 57 +++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared GPIO package: default widths for the input filter block.
package gpio_pkg;

    localparam int GPIO_INFILT_CNT_W = 4;
    localparam int GPIO_INFILT_DIV_W = 16;

endpackage

// File: rtl/gpio_infilt_cell.sv
// One pin of the input filter: 2-flop synchronizer, debounce counter, filtered output.
// GPIO_INFILT_EDGE_EN adds registered rise/fall pulses on the filtered level.
module gpio_infilt_cell
    import gpio_pkg::*;
#(
    parameter int CNT_WIDTH = GPIO_INFILT_CNT_W
) (
    input  logic                 pclk,
    input  logic                 prst,
    input  logic                 i_pad,
    input  logic                 i_en,
    input  logic                 i_tick,
    input  logic [CNT_WIDTH-1:0] i_thr,
    output logic                 o_level,
    output logic                 o_stable
`ifdef GPIO_INFILT_EDGE_EN
    ,
    output logic                 o_rise,
    output logic                 o_fall
`endif
);

    logic                 r_s1;
    logic                 r_s2;
    logic                 r_out;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH:0]   w_cnt_inc;
    logic [CNT_WIDTH:0]   w_thr_eff;

    // One extra bit so the compare never sees a wrapped count.
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_WIDTH+1)'(1);
    assign w_thr_eff = (i_thr == '0) ? (CNT_WIDTH+1)'(1) : {1'b0, i_thr};

    always_ff @(posedge pclk) begin
        if (prst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_out <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_pad;
            r_s2 <= r_s1;
            if (!i_en) begin
                r_out <= r_s2;
                r_cnt <= '0;
            end else if (r_s2 == r_out) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (w_cnt_inc >= w_thr_eff) begin
                    r_out <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_inc[CNT_WIDTH-1:0];
                end
            end
        end
    end

    assign o_level  = r_out;
    assign o_stable = prst | (r_cnt == '0);

`ifdef GPIO_INFILT_EDGE_EN
    logic r_prev;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge pclk) begin
        if (prst) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= r_out;
            r_rise <= r_out & ~r_prev;
            r_fall <= ~r_out & r_prev;
        end
    end

    assign o_rise = r_rise & ~prst;
    assign o_fall = r_fall & ~prst;
`endif

endmodule

// File: rtl/gpio_infilt.sv
// GPIO input filter: shared sample-tick prescaler feeding GPIO_NUM debounce cells.
// Define GPIO_INFILT_EDGE_EN to add the rise_o / fall_o pulse outputs.
module gpio_infilt
    import gpio_pkg::*;
#(
    parameter int GPIO_NUM  = 32,
    parameter int CNT_WIDTH = GPIO_INFILT_CNT_W,
    parameter int DIV_WIDTH = GPIO_INFILT_DIV_W
) (
    input  logic                 pclk,
    input  logic                 prst,
    input  logic [GPIO_NUM-1:0]  gpio_in_i,
    input  logic [GPIO_NUM-1:0]  flt_en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [CNT_WIDTH-1:0] thr_i,
    output logic [GPIO_NUM-1:0]  gpio_in_o,
    output logic [GPIO_NUM-1:0]  stable_o
`ifdef GPIO_INFILT_EDGE_EN
    ,
    output logic [GPIO_NUM-1:0]  rise_o,
    output logic [GPIO_NUM-1:0]  fall_o
`endif
);

    logic [DIV_WIDTH-1:0] r_div_cnt;
    logic                 w_tick;

    // >= rather than == so a period shortened below the count ticks at once.
    assign w_tick = (r_div_cnt >= div_i);

    always_ff @(posedge pclk) begin
        if (prst)        r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + 1'b1;
    end

    for (genvar g = 0; g < GPIO_NUM; g++) begin : g_pin
        gpio_infilt_cell #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cell (
            .pclk     (pclk),
            .prst     (prst),
            .i_pad    (gpio_in_i[g]),
            .i_en     (flt_en_i[g]),
            .i_tick   (w_tick),
            .i_thr    (thr_i),
            .o_level  (gpio_in_o[g]),
            .o_stable (stable_o[g])
`ifdef GPIO_INFILT_EDGE_EN
            ,
            .o_rise   (rise_o[g]),
            .o_fall   (fall_o[g])
`endif
        );
    end

endmodule
